// File: rtl/reservation_stations_if.sv
// Dispatch, CDB, issue-free and entry-status bundle for reservation_stations.
// The slave modport is the reservation-station side; master is the driver side.
interface reservation_stations_if #(
  parameter int RS_SIZE = 8,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int CTRL_W  = 16
) ();
  localparam int IDX_W = $clog2(RS_SIZE);

  logic                       flush;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [DATA_W-1:0]          disp_value_1;
  logic [DATA_W-1:0]          disp_value_2;
  logic [DATA_W-1:0]          disp_imm;
  logic [TAG_W-1:0]           disp_tag_1;
  logic [TAG_W-1:0]           disp_tag_2;
  logic [TAG_W-1:0]           disp_dest_tag;
  logic [CTRL_W-1:0]          disp_ctrl;
  logic [IDX_W-1:0]           disp_id;
  logic                       cdb1_valid;
  logic [TAG_W-1:0]           cdb1_tag;
  logic [DATA_W-1:0]          cdb1_value;
  logic                       cdb2_valid;
  logic [TAG_W-1:0]           cdb2_tag;
  logic [DATA_W-1:0]          cdb2_value;
  logic                       iss_free_valid;
  logic [IDX_W-1:0]           iss_free_id;
  logic [RS_SIZE-1:0]         rs_busy;
  logic [RS_SIZE-1:0]         rs_ready;
  logic [RS_SIZE*DATA_W-1:0]  rs_value_1;
  logic [RS_SIZE*DATA_W-1:0]  rs_value_2;
  logic [RS_SIZE*DATA_W-1:0]  rs_imm;
  logic [RS_SIZE*TAG_W-1:0]   rs_tag_1;
  logic [RS_SIZE*TAG_W-1:0]   rs_tag_2;
  logic [RS_SIZE*TAG_W-1:0]   rs_dest_tag;
  logic [RS_SIZE*CTRL_W-1:0]  rs_ctrl;
  logic [IDX_W:0]             free_count;

  modport slave (
    input  flush, disp_valid, disp_value_1, disp_value_2, disp_imm,
           disp_tag_1, disp_tag_2, disp_dest_tag, disp_ctrl,
           cdb1_valid, cdb1_tag, cdb1_value, cdb2_valid, cdb2_tag, cdb2_value,
           iss_free_valid, iss_free_id,
    output disp_ready, disp_id, rs_busy, rs_ready, rs_value_1, rs_value_2,
           rs_imm, rs_tag_1, rs_tag_2, rs_dest_tag, rs_ctrl, free_count
  );

  modport master (
    output flush, disp_valid, disp_value_1, disp_value_2, disp_imm,
           disp_tag_1, disp_tag_2, disp_dest_tag, disp_ctrl,
           cdb1_valid, cdb1_tag, cdb1_value, cdb2_valid, cdb2_tag, cdb2_value,
           iss_free_valid, iss_free_id,
    input  disp_ready, disp_id, rs_busy, rs_ready, rs_value_1, rs_value_2,
           rs_imm, rs_tag_1, rs_tag_2, rs_dest_tag, rs_ctrl, free_count
  );
endinterface

// File: rtl/reservation_stations.sv
// Reservation station: lowest-free-slot dispatch, dual-CDB wakeup/bypass, flush.
// Define RS_SECOND_CDB_EN to let cdb2 wake entries; otherwise only cdb1 does.
module reservation_stations #(
  parameter int RS_SIZE = 8,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int CTRL_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  reservation_stations_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] r_busy;
  logic [DATA_W-1:0]  r_val1 [RS_SIZE];
  logic [DATA_W-1:0]  r_val2 [RS_SIZE];
  logic [DATA_W-1:0]  r_imm  [RS_SIZE];
  logic [TAG_W-1:0]   r_tag1 [RS_SIZE];
  logic [TAG_W-1:0]   r_tag2 [RS_SIZE];
  logic [TAG_W-1:0]   r_dest [RS_SIZE];
  logic [CTRL_W-1:0]  r_ctrl [RS_SIZE];

  logic [RS_SIZE-1:0] w_nbusy;
  logic [DATA_W-1:0]  w_nval1 [RS_SIZE];
  logic [DATA_W-1:0]  w_nval2 [RS_SIZE];
  logic [DATA_W-1:0]  w_nimm  [RS_SIZE];
  logic [TAG_W-1:0]   w_ntag1 [RS_SIZE];
  logic [TAG_W-1:0]   w_ntag2 [RS_SIZE];
  logic [TAG_W-1:0]   w_ndest [RS_SIZE];
  logic [CTRL_W-1:0]  w_nctrl [RS_SIZE];

  logic               w_cdb2_valid;
  logic [IDX_W-1:0]   w_disp_id;
  logic               w_disp_ready;
  logic [CNT_W-1:0]   w_free_count;
  logic               w_found;

`ifdef RS_SECOND_CDB_EN
  assign w_cdb2_valid = bus.cdb2_valid;
`else
  logic w_unused_cdb2;
  assign w_cdb2_valid  = 1'b0;
  assign w_unused_cdb2 = ^{bus.cdb2_valid, bus.cdb2_tag, bus.cdb2_value};
`endif

  // Returns {tag, value} after CDB capture; cdb1 is applied last so it wins ties.
  function automatic logic [TAG_W+DATA_W-1:0] resolve(
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] val
  );
    logic [TAG_W+DATA_W-1:0] res;
    res = {tag, val};
    if (tag != '0) begin
      if (w_cdb2_valid && bus.cdb2_tag == tag) res = {{TAG_W{1'b0}}, bus.cdb2_value};
      if (bus.cdb1_valid && bus.cdb1_tag == tag) res = {{TAG_W{1'b0}}, bus.cdb1_value};
    end
    return res;
  endfunction

  always_comb begin
    w_disp_id    = '0;
    w_found      = 1'b0;
    w_free_count = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!w_found && !r_busy[i]) begin
        w_disp_id = IDX_W'(i);
        w_found   = 1'b1;
      end
      w_free_count = w_free_count + CNT_W'(!r_busy[i]);
    end
    w_disp_ready = ~&r_busy;
  end

  always_comb begin
    w_nbusy = r_busy;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      {w_ntag1[i], w_nval1[i]} = {r_tag1[i], r_val1[i]};
      {w_ntag2[i], w_nval2[i]} = {r_tag2[i], r_val2[i]};
      w_nimm[i]  = r_imm[i];
      w_ndest[i] = r_dest[i];
      w_nctrl[i] = r_ctrl[i];
      if (r_busy[i]) begin
        {w_ntag1[i], w_nval1[i]} = resolve(r_tag1[i], r_val1[i]);
        {w_ntag2[i], w_nval2[i]} = resolve(r_tag2[i], r_val2[i]);
        if (bus.iss_free_valid && bus.iss_free_id == IDX_W'(i)) w_nbusy[i] = 1'b0;
      end
      // Dispatch slot is never busy, so a same-cycle free of it is a no-op.
      if (bus.disp_valid && w_disp_ready && w_disp_id == IDX_W'(i)) begin
        w_nbusy[i] = 1'b1;
        {w_ntag1[i], w_nval1[i]} = resolve(bus.disp_tag_1, bus.disp_value_1);
        {w_ntag2[i], w_nval2[i]} = resolve(bus.disp_tag_2, bus.disp_value_2);
        w_nimm[i]  = bus.disp_imm;
        w_ndest[i] = bus.disp_dest_tag;
        w_nctrl[i] = bus.disp_ctrl;
      end
      if (bus.flush) w_nbusy[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        r_val1[i] <= '0;
        r_val2[i] <= '0;
        r_imm[i]  <= '0;
        r_tag1[i] <= '0;
        r_tag2[i] <= '0;
        r_dest[i] <= '0;
        r_ctrl[i] <= '0;
      end
    end else begin
      r_busy <= w_nbusy;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        r_val1[i] <= w_nval1[i];
        r_val2[i] <= w_nval2[i];
        r_imm[i]  <= w_nimm[i];
        r_tag1[i] <= w_ntag1[i];
        r_tag2[i] <= w_ntag2[i];
        r_dest[i] <= w_ndest[i];
        r_ctrl[i] <= w_nctrl[i];
      end
    end
  end

  logic [RS_SIZE-1:0]        w_ready;
  logic [RS_SIZE*DATA_W-1:0] w_val1_flat, w_val2_flat, w_imm_flat;
  logic [RS_SIZE*TAG_W-1:0]  w_tag1_flat, w_tag2_flat, w_dest_flat;
  logic [RS_SIZE*CTRL_W-1:0] w_ctrl_flat;

  always_comb begin
    w_ready     = '0;
    w_val1_flat = '0;
    w_val2_flat = '0;
    w_imm_flat  = '0;
    w_tag1_flat = '0;
    w_tag2_flat = '0;
    w_dest_flat = '0;
    w_ctrl_flat = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] && r_tag1[i] == '0 && r_tag2[i] == '0;
      w_val1_flat[i*DATA_W +: DATA_W] = r_val1[i];
      w_val2_flat[i*DATA_W +: DATA_W] = r_val2[i];
      w_imm_flat[i*DATA_W +: DATA_W]  = r_imm[i];
      w_tag1_flat[i*TAG_W +: TAG_W]   = r_tag1[i];
      w_tag2_flat[i*TAG_W +: TAG_W]   = r_tag2[i];
      w_dest_flat[i*TAG_W +: TAG_W]   = r_dest[i];
      w_ctrl_flat[i*CTRL_W +: CTRL_W] = r_ctrl[i];
    end
  end

  assign bus.disp_ready  = w_disp_ready;
  assign bus.disp_id     = w_disp_id;
  assign bus.free_count  = w_free_count;
  assign bus.rs_busy     = r_busy;
  assign bus.rs_ready    = w_ready;
  assign bus.rs_value_1  = w_val1_flat;
  assign bus.rs_value_2  = w_val2_flat;
  assign bus.rs_imm      = w_imm_flat;
  assign bus.rs_tag_1    = w_tag1_flat;
  assign bus.rs_tag_2    = w_tag2_flat;
  assign bus.rs_dest_tag = w_dest_flat;
  assign bus.rs_ctrl     = w_ctrl_flat;
endmodule

// File: tb/tb_reservation_stations.sv
// Self-checking bench for reservation_stations; expectations follow RS_SECOND_CDB_EN.
module tb_reservation_stations;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int CW = 16;
  localparam int IW = 3;
`ifdef RS_SECOND_CDB_EN
  localparam bit CDB2_ON = 1'b1;
`else
  localparam bit CDB2_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int unsigned   id;
    logic [DW-1:0] v1;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
  } exp_t;
  exp_t sb[$];

  reservation_stations_if #(.RS_SIZE(N), .DATA_W(DW), .TAG_W(TW), .CTRL_W(CW)) bus ();

  reservation_stations #(.RS_SIZE(N), .DATA_W(DW), .TAG_W(TW), .CTRL_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] v1(int unsigned i); return bus.rs_value_1[i*DW +: DW]; endfunction
  function automatic logic [DW-1:0] v2(int unsigned i); return bus.rs_value_2[i*DW +: DW]; endfunction
  function automatic logic [DW-1:0] im(int unsigned i); return bus.rs_imm[i*DW +: DW]; endfunction
  function automatic logic [TW-1:0] t1(int unsigned i); return bus.rs_tag_1[i*TW +: TW]; endfunction
  function automatic logic [TW-1:0] t2(int unsigned i); return bus.rs_tag_2[i*TW +: TW]; endfunction
  function automatic logic [CW-1:0] ct(int unsigned i); return bus.rs_ctrl[i*CW +: CW]; endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.disp_valid = 1'b0;
    bus.disp_value_1 = '0; bus.disp_value_2 = '0; bus.disp_imm = '0;
    bus.disp_tag_1 = '0; bus.disp_tag_2 = '0; bus.disp_dest_tag = '0; bus.disp_ctrl = '0;
    bus.cdb1_valid = 1'b0; bus.cdb1_tag = '0; bus.cdb1_value = '0;
    bus.cdb2_valid = 1'b0; bus.cdb2_tag = '0; bus.cdb2_value = '0;
    bus.iss_free_valid = 1'b0; bus.iss_free_id = '0;
  endtask

  task automatic drv_disp(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] imm,
                          logic [TW-1:0] ta, logic [TW-1:0] tb, logic [CW-1:0] ctrl);
    bus.disp_valid = 1'b1; bus.disp_value_1 = a; bus.disp_value_2 = b; bus.disp_imm = imm;
    bus.disp_tag_1 = ta; bus.disp_tag_2 = tb; bus.disp_dest_tag = 6'd1; bus.disp_ctrl = ctrl;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic fill(int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      drv_disp(DW'(32'h1000 + k), '0, '0, '0, '0, '0);
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    drv_disp(32'h12, 32'h34, 32'h56, 6'd3, 6'd4, 16'h1);
    step(); step();
    reset = 1'b0;
    idle();
    checks++; if (bus.rs_busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", bus.rs_busy); end
    checks++; if (bus.rs_ready !== 8'h00) begin errors++; $display("FAIL reset_ready got %h exp 00", bus.rs_ready); end
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got %b exp 1", bus.disp_ready); end
    checks++; if (bus.disp_id !== 3'd0) begin errors++; $display("FAIL reset_disp_id got %0d exp 0", bus.disp_id); end
    checks++; if (bus.free_count !== 4'd8) begin errors++; $display("FAIL reset_free_count got %0d exp 8", bus.free_count); end
  endtask

  task automatic test_fill();
    exp_t e;
    do_reset();
    for (int unsigned k = 0; k < N; k++) begin
      drv_disp(DW'(32'h100 + k), DW'(32'h300 + k), DW'(32'h200 + k), '0, '0, CW'(16'hA000 + k));
      checks++; if (bus.disp_id !== IW'(k)) begin errors++; $display("FAIL fill_disp_id got %0d exp %0d", bus.disp_id, k); end
      sb.push_back('{id: k, v1: DW'(32'h100 + k), imm: DW'(32'h200 + k), ctrl: CW'(16'hA000 + k)});
      step();
      e = sb.pop_front();
      checks++; if (v1(e.id) !== e.v1) begin errors++; $display("FAIL fill_value_1[%0d] got %h exp %h", e.id, v1(e.id), e.v1); end
      checks++; if (im(e.id) !== e.imm) begin errors++; $display("FAIL fill_imm[%0d] got %h exp %h", e.id, im(e.id), e.imm); end
      checks++; if (ct(e.id) !== e.ctrl) begin errors++; $display("FAIL fill_ctrl[%0d] got %h exp %h", e.id, ct(e.id), e.ctrl); end
      checks++; if (bus.rs_ready[e.id] !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b exp 1", e.id, bus.rs_ready[e.id]); end
    end
    checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready got %b exp 0", bus.disp_ready); end
    checks++; if (bus.free_count !== 4'd0) begin errors++; $display("FAIL full_free_count got %0d exp 0", bus.free_count); end
    drv_disp(32'hBAD, 32'hBAD, 32'hBAD, '0, '0, '0);
    step();
    idle();
    checks++; if (bus.rs_busy !== 8'hFF) begin errors++; $display("FAIL ninth_busy got %h exp ff", bus.rs_busy); end
    checks++; if (v1(0) !== 32'h100) begin errors++; $display("FAIL ninth_value_1[0] got %h exp 100", v1(0)); end
  endtask

  task automatic test_wakeup();
    do_reset();
    for (int unsigned k = 0; k < 4; k++) begin
      if (k == 3) drv_disp(32'h0, 32'h0, 32'h0, 6'd5, 6'd0, 16'h3);
      else        drv_disp(32'h55, 32'h0, 32'h0, 6'd0, 6'd0, 16'h0);
      step();
    end
    idle();
    checks++; if (bus.rs_ready[3] !== 1'b0) begin errors++; $display("FAIL wait_ready[3] got %b exp 0", bus.rs_ready[3]); end
    checks++; if (t1(3) !== 6'd5) begin errors++; $display("FAIL wait_tag_1[3] got %0d exp 5", t1(3)); end
    bus.cdb1_valid = 1'b1; bus.cdb1_tag = 6'd5; bus.cdb1_value = 32'hDEAD;
    step();
    idle();
    checks++; if (v1(3) !== 32'hDEAD) begin errors++; $display("FAIL wake_value_1[3] got %h exp dead", v1(3)); end
    checks++; if (t1(3) !== 6'd0) begin errors++; $display("FAIL wake_tag_1[3] got %0d exp 0", t1(3)); end
    checks++; if (bus.rs_ready[3] !== 1'b1) begin errors++; $display("FAIL wake_ready[3] got %b exp 1", bus.rs_ready[3]); end
    bus.cdb1_valid = 1'b1; bus.cdb1_tag = 6'd0; bus.cdb1_value = 32'h99;
    step();
    idle();
    checks++; if (v1(0) !== 32'h55) begin errors++; $display("FAIL tag0_value_1[0] got %h exp 55", v1(0)); end
  endtask

  task automatic test_bypass();
    do_reset();
    drv_disp(32'h0, 32'h0, 32'h0, 6'd0, 6'd7, 16'h0);
    bus.cdb2_valid = 1'b1; bus.cdb2_tag = 6'd7; bus.cdb2_value = 32'h42;
    step();
    idle();
    checks++; if (t2(0) !== (CDB2_ON ? 6'd0 : 6'd7)) begin errors++; $display("FAIL byp2_tag_2[0] got %0d exp %0d", t2(0), CDB2_ON ? 0 : 7); end
    checks++; if (v2(0) !== (CDB2_ON ? 32'h42 : 32'h0)) begin errors++; $display("FAIL byp2_value_2[0] got %h exp %h", v2(0), CDB2_ON ? 32'h42 : 32'h0); end
    checks++; if (bus.rs_ready[0] !== CDB2_ON) begin errors++; $display("FAIL byp2_ready[0] got %b exp %b", bus.rs_ready[0], CDB2_ON); end
    drv_disp(32'h0, 32'h0, 32'h0, 6'd3, 6'd0, 16'h0);
    bus.cdb1_valid = 1'b1; bus.cdb1_tag = 6'd3; bus.cdb1_value = 32'h77;
    step();
    idle();
    checks++; if (v1(1) !== 32'h77) begin errors++; $display("FAIL byp1_value_1[1] got %h exp 77", v1(1)); end
    checks++; if (bus.rs_ready[1] !== 1'b1) begin errors++; $display("FAIL byp1_ready[1] got %b exp 1", bus.rs_ready[1]); end
    drv_disp(32'h0, 32'h0, 32'h0, 6'd0, 6'd11, 16'h0);
    step();
    idle();
    bus.cdb2_valid = 1'b1; bus.cdb2_tag = 6'd11; bus.cdb2_value = 32'h5A5A;
    step();
    idle();
    checks++; if (t2(2) !== (CDB2_ON ? 6'd0 : 6'd11)) begin errors++; $display("FAIL wake2_tag_2[2] got %0d exp %0d", t2(2), CDB2_ON ? 0 : 11); end
    checks++; if (v2(2) !== (CDB2_ON ? 32'h5A5A : 32'h0)) begin errors++; $display("FAIL wake2_value_2[2] got %h exp %h", v2(2), CDB2_ON ? 32'h5A5A : 32'h0); end
  endtask

  task automatic test_cdb_priority();
    do_reset();
    drv_disp(32'h0, 32'h0, 32'h0, 6'd9, 6'd0, 16'h0);
    step();
    drv_disp(32'h0, 32'h0, 32'h0, 6'd0, 6'd9, 16'h0);
    bus.cdb1_valid = 1'b1; bus.cdb1_tag = 6'd9; bus.cdb1_value = 32'h1;
    bus.cdb2_valid = 1'b1; bus.cdb2_tag = 6'd9; bus.cdb2_value = 32'h2;
    step();
    idle();
    checks++; if (v1(0) !== 32'h1) begin errors++; $display("FAIL prio_wake_value_1[0] got %h exp 1", v1(0)); end
    checks++; if (t1(0) !== 6'd0) begin errors++; $display("FAIL prio_wake_tag_1[0] got %0d exp 0", t1(0)); end
    checks++; if (v2(1) !== 32'h1) begin errors++; $display("FAIL prio_byp_value_2[1] got %h exp 1", v2(1)); end
  endtask

  task automatic test_free_full();
    do_reset();
    fill(N);
    bus.iss_free_valid = 1'b1; bus.iss_free_id = 3'd4;
    drv_disp(32'hF4, 32'h0, 32'h0, 6'd0, 6'd0, 16'h0);
    step();
    idle();
    checks++; if (bus.rs_busy !== 8'hEF) begin errors++; $display("FAIL free4_busy got %h exp ef", bus.rs_busy); end
    checks++; if (bus.free_count !== 4'd1) begin errors++; $display("FAIL free4_free_count got %0d exp 1", bus.free_count); end
    checks++; if (bus.disp_id !== 3'd4) begin errors++; $display("FAIL free4_disp_id got %0d exp 4", bus.disp_id); end
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL free4_disp_ready got %b exp 1", bus.disp_ready); end
    drv_disp(32'h444, 32'h0, 32'h0, 6'd0, 6'd0, 16'h0);
    step();
    idle();
    checks++; if (bus.rs_busy !== 8'hFF) begin errors++; $display("FAIL redisp_busy got %h exp ff", bus.rs_busy); end
    checks++; if (v1(4) !== 32'h444) begin errors++; $display("FAIL redisp_value_1[4] got %h exp 444", v1(4)); end
    bus.iss_free_valid = 1'b1; bus.iss_free_id = 3'd1;
    step();
    idle();
    checks++; if (bus.rs_busy !== 8'hFD) begin errors++; $display("FAIL free1_busy got %h exp fd", bus.rs_busy); end
    bus.iss_free_valid = 1'b1; bus.iss_free_id = 3'd6;
    drv_disp(32'h111, 32'h0, 32'h0, 6'd0, 6'd0, 16'h0);
    step();
    idle();
    checks++; if (bus.rs_busy !== 8'hBF) begin errors++; $display("FAIL free6_disp1_busy got %h exp bf", bus.rs_busy); end
    checks++; if (v1(1) !== 32'h111) begin errors++; $display("FAIL free6_disp1_value_1[1] got %h exp 111", v1(1)); end
    bus.iss_free_valid = 1'b1; bus.iss_free_id = 3'd6;
    step();
    idle();
    checks++; if (bus.rs_busy !== 8'hBF) begin errors++; $display("FAIL free_idle_busy got %h exp bf", bus.rs_busy); end
    checks++; if (bus.free_count !== 4'd1) begin errors++; $display("FAIL free_idle_count got %0d exp 1", bus.free_count); end
  endtask

  task automatic test_flush();
    do_reset();
    fill(5);
    checks++; if (bus.free_count !== 4'd3) begin errors++; $display("FAIL five_free_count got %0d exp 3", bus.free_count); end
    checks++; if (bus.rs_busy !== 8'h1F) begin errors++; $display("FAIL five_busy got %h exp 1f", bus.rs_busy); end
    bus.flush = 1'b1;
    drv_disp(32'h9, 32'h0, 32'h0, 6'd0, 6'd0, 16'h0);
    bus.cdb1_valid = 1'b1; bus.cdb1_tag = 6'd2; bus.cdb1_value = 32'h8;
    step();
    idle();
    checks++; if (bus.rs_busy !== 8'h00) begin errors++; $display("FAIL flush_busy got %h exp 00", bus.rs_busy); end
    checks++; if (bus.free_count !== 4'd8) begin errors++; $display("FAIL flush_free_count got %0d exp 8", bus.free_count); end
    checks++; if (bus.disp_id !== 3'd0) begin errors++; $display("FAIL flush_disp_id got %0d exp 0", bus.disp_id); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int unsigned k = 0; k < 3; k++) begin
      drv_disp(32'h33, 32'h44, 32'h0, 6'd2, 6'd3, 16'h0);
      step();
    end
    idle();
    reset = 1'b1;
    bus.flush = 1'b1;
    drv_disp(32'h66, 32'h0, 32'h0, 6'd0, 6'd0, 16'h0);
    bus.cdb1_valid = 1'b1; bus.cdb1_tag = 6'd2; bus.cdb1_value = 32'h7;
    bus.iss_free_valid = 1'b1; bus.iss_free_id = 3'd0;
    step();
    reset = 1'b0;
    idle();
    checks++; if (bus.rs_busy !== 8'h00) begin errors++; $display("FAIL rstmid_busy got %h exp 00", bus.rs_busy); end
    checks++; if (bus.free_count !== 4'd8) begin errors++; $display("FAIL rstmid_free_count got %0d exp 8", bus.free_count); end
    checks++; if (bus.rs_tag_1 !== '0) begin errors++; $display("FAIL rstmid_tag_1 got %h exp 0", bus.rs_tag_1); end
    checks++; if (bus.rs_value_1 !== '0) begin errors++; $display("FAIL rstmid_value_1 got %h exp 0", bus.rs_value_1); end
    checks++; if (bus.rs_ready !== 8'h00) begin errors++; $display("FAIL rstmid_ready got %h exp 00", bus.rs_ready); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    test_reset();
    test_fill();
    test_wakeup();
    test_bypass();
    test_cdb_priority();
    test_free_full();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reservation_stations.md
RESERVATION_STATIONS -- requirements
Module: reservation_stations

Interface
REQ-001 Parameter RS_SIZE, 8, number of entries (power of two, 2..16).
REQ-002 Parameter DATA_W, 32, operand/immediate width.
REQ-003 Parameter TAG_W, 6, producer tag width; tag 0 means "operand value valid".
REQ-004 Parameter CTRL_W, 16, opaque control-bit width carried with each entry.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  clears all entries (branch mispredict).
REQ-008 disp_valid  input  1  dispatch request.
REQ-009 disp_ready  output  1  at least one free entry (registered state).
REQ-010 disp_value_1 / disp_value_2 / disp_imm  input  DATA_W each  source values, immediate.
REQ-011 disp_tag_1 / disp_tag_2  input  TAG_W each  pending producer tags.
REQ-012 disp_dest_tag  input  TAG_W  tag this instruction broadcasts on completion.
REQ-013 disp_ctrl  input  CTRL_W  control bits.
REQ-014 disp_id  output  clog2(RS_SIZE)  index the current dispatch will occupy.
REQ-015 cdb1_valid / cdb2_valid  input  1 each  result broadcast valid.
REQ-016 cdb1_tag / cdb2_tag  input  TAG_W each  broadcast tag.
REQ-017 cdb1_value / cdb2_value  input  DATA_W each  broadcast value.
REQ-018 iss_free_valid  input  1  issue stage consumed an entry.
REQ-019 iss_free_id  input  clog2(RS_SIZE)  index of consumed entry.
REQ-020 rs_busy / rs_ready  output  RS_SIZE each  per-entry busy; busy and both tags 0.
REQ-021 rs_value_1 / rs_value_2 / rs_imm  output  RS_SIZE*DATA_W each  flattened entry fields, entry i at bits [i*DATA_W +: DATA_W].
REQ-022 rs_tag_1 / rs_tag_2 / rs_dest_tag  output  RS_SIZE*TAG_W each  flattened tags.
REQ-023 rs_ctrl  output  RS_SIZE*CTRL_W  flattened control bits.
REQ-024 free_count  output  clog2(RS_SIZE)+1  number of non-busy entries.

Function
REQ-025 disp_id = lowest-index non-busy entry; disp_ready = any entry non-busy; both combinational from registered busy only.
REQ-026 disp_valid && disp_ready: entry disp_id written and busy set next edge; disp_valid && !disp_ready ignored, no state change.
REQ-027 Wakeup: each busy entry with tag_k != 0 matching a valid CDB tag captures that value into value_k and clears tag_k next edge.
REQ-028 Both CDB ports matching the same nonzero tag: cdb1 value wins.
REQ-029 Dispatch bypass: disp_tag_k != 0 matching a same-cycle valid CDB tag is written as tag 0 with the CDB value.
REQ-030 Broadcast tag 0 never wakes anything.
REQ-031 iss_free_valid clears busy of iss_free_id next edge; freeing a non-busy entry has no effect.
REQ-032 A slot freed in cycle N is dispatchable from cycle N+1 only; free and dispatch to different slots in the same cycle both take effect.
REQ-033 free_count tracks registered busy: RS_SIZE minus popcount(rs_busy).
REQ-034 Fields of non-busy entries are don't-care; rs_ready for non-busy entries is 0.
REQ-035 flush clears all busy next edge; flush overrides dispatch and wakeup in the same cycle.

Reset
REQ-036 reset clears all busy, tags and values to 0; after reset rs_busy=0, rs_ready=0, disp_ready=1, disp_id=0, free_count=RS_SIZE.
REQ-037 reset mid-operation discards all entries regardless of concurrent dispatch, CDB or free; reset has priority over flush.

Configuration
REQ-038 Macro RS_SECOND_CDB_EN defined: cdb2 port participates in wakeup and dispatch bypass per REQ-027..029.
REQ-039 RS_SECOND_CDB_EN undefined: cdb2 ports remain present but are ignored; only cdb1 wakes entries.

Verification
REQ-040 Reset, dispatch 8 entries with tags 0 -> disp_id 0..7 in order, disp_ready 0 after 8th, free_count 0, 9th dispatch ignored.
REQ-041 Entry 3 tag_1=5; cdb1 tag 5 value 0xDEAD -> next cycle rs_value_1[3]=0xDEAD, tag_1=0, rs_ready[3]=1.
REQ-042 Dispatch tag_2=7 while cdb2 tag 7 value 0x42 (macro on) -> entry ready with value_2=0x42; macro off -> tag_2 stays 7.
REQ-043 Full RS, free id 4 with simultaneous dispatch -> dispatch ignored that cycle, next cycle disp_id=4 accepted.
REQ-044 cdb1 and cdb2 both tag 9 values 0x1/0x2 -> waiting entry captures 0x1.
REQ-045 Five busy entries, flush with dispatch -> next cycle rs_busy=0, free_count=8.
